// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the shared data-memory/MMIO port.
// The pipeline MEM stage (C) owns the port by default; a debug/loader DMA (D) gets bursts and starvation slots.
module dmem_port_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic        c_rd,
  input  logic        c_wr,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  input  logic        d_last,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [31:0] m_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    CPU   = 2'd0,
    DEV   = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [BW-1:0]   beat_inc;
  logic [WW-1:0]   wait_inc;
  logic            creq;
  logic            gnt_c;
  logic            gnt_d;

  assign creq     = c_rd | c_wr;
  assign beat_inc = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + BW'(1);
  assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WW'(1);

  // Grant decode is combinational; nobody owns the port while reset is high.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (!reset) begin
      case (state)
        CPU: begin
          if (creq)       gnt_c = 1'b1;
          else if (d_req) gnt_d = 1'b1;
        end
        DEV, FORCE: begin
          if (d_req)      gnt_d = 1'b1;
          else if (creq)  gnt_c = 1'b1;
        end
        default: gnt_c = creq;
      endcase
    end
  end

  assign d_gnt   = gnt_d;
  assign c_stall = creq & ~gnt_c & ~reset;

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    c_rdata = '0;
    if (gnt_c) begin
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_rd    = c_rd;
      m_wr    = c_wr;
      c_rdata = m_rdata;
    end else if (gnt_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_rd    = ~d_we;
      m_wr    = d_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CPU;
      beat_cnt <= '0;
      wait_cnt <= '0;
      d_rdata  <= '0;
      d_rvalid <= 1'b0;
    end else begin
      d_rvalid <= gnt_d & ~d_we;
      if (gnt_d && !d_we) d_rdata <= m_rdata;

      case (state)
        CPU: begin
          if (creq) begin
            beat_cnt <= '0;
            if (d_req) begin
              wait_cnt <= wait_inc;
              if (wait_inc == WAIT_MAX) state <= FORCE;
            end else begin
              wait_cnt <= '0;
            end
          end else if (d_req) begin
            wait_cnt <= '0;
            if (d_last || MAX_BURST == 1) begin
              beat_cnt <= '0;
            end else begin
              beat_cnt <= BW'(1);
              state    <= DEV;
            end
          end else begin
            wait_cnt <= '0;
          end
        end

        DEV: begin
          if (d_req && !d_last && beat_inc != BEAT_MAX) begin
            beat_cnt <= beat_inc;
          end else begin
            state    <= CPU;
            beat_cnt <= '0;
            wait_cnt <= '0;
          end
        end

        FORCE: begin
          state    <= CPU;
          beat_cnt <= '0;
          wait_cnt <= '0;
        end

        default: begin
          state    <= CPU;
          beat_cnt <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter; the bench itself plays the data memory.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_rd, c_wr, c_stall;
  logic        d_req, d_we, d_last, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_rd, m_wr;

  int n_cmp = 0;
  int n_err = 0;

  logic        mem_clr;
  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MAX_BURST(8), .STARVE_LIMIT(16)) dut (
    .clk(clk), .reset(reset),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rd(c_rd), .c_wr(c_wr),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_last(d_last),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr), .m_rdata(m_rdata)
  );

  // RAM plus the two MMIO registers share one array; bit 30 separates the MMIO page.
  always_comb m_rdata = mem[{m_addr[30], m_addr[11:2]}];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
    end else if (m_wr) begin
      mem[{m_addr[30], m_addr[11:2]}] <= m_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    c_rd = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_last = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic d_set(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic last);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_last = last;
  endtask

  initial begin
    reset = 1; mem_clr = 1;
    idle_inputs();
    next_cycle();
    next_cycle();

    // reset: requests present but nothing may reach memory
    c_rd = 1; d_set(1'b1, 32'h400, 32'hFFFF, 1'b0);
    sample();
    chk("rst_c_stall", c_stall, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_rd", m_rd, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_d_rdata", d_rdata, 0);
    next_cycle();
    reset = 0; mem_clr = 0;
    idle_inputs();
    next_cycle();

    // T1: C-only LED write then read
    c_wr = 1; c_addr = 32'h4000000C; c_wdata = 32'h000000A5;
    sample();
    chk("t1_wr_stall", c_stall, 0);
    chk("t1_m_wr", m_wr, 1);
    chk("t1_m_addr", m_addr, 32'h4000000C);
    next_cycle();
    c_wr = 0; c_rd = 1;
    sample();
    chk("t1_rd_stall", c_stall, 0);
    chk("t1_m_rd", m_rd, 1);
    chk("t1_c_rdata", c_rdata, 32'h000000A5);
    next_cycle();
    idle_inputs();

    // T2: 4-beat D write burst with C idle
    for (int i = 0; i < 4; i++) begin
      d_set(1'b1, 32'h400 + 4 * i, 32'h1000 + i, i == 3);
      sample();
      chk($sformatf("t2_gnt_%0d", i), d_gnt, 1);
      chk($sformatf("t2_wdata_%0d", i), m_wdata, 32'h1000 + i);
      next_cycle();
    end
    // back in CPU: C wins a simultaneous request
    d_set(1'b0, 32'h404, 32'h0, 1'b1);
    c_rd = 1; c_addr = 32'h40C;
    sample();
    chk("t2_cpu_stall", c_stall, 0);
    chk("t2_cpu_dgnt", d_gnt, 0);
    chk("t2_rd_40c", c_rdata, 32'h1003);
    next_cycle();
    d_req = 0; c_addr = 32'h400;
    sample();
    chk("t2_rd_400", c_rdata, 32'h1000);
    next_cycle();
    idle_inputs();

    // T3: 12-beat D burst, MAX_BURST=8, C starts requesting after beat 1
    d_set(1'b1, 32'h800, 32'h2000, 1'b0);
    sample();
    chk("t3_b0_gnt", d_gnt, 1);
    chk("t3_b0_stall", c_stall, 0);
    next_cycle();
    c_rd = 1; c_addr = 32'h400;
    for (int i = 1; i < 8; i++) begin
      d_set(1'b1, 32'h800 + 4 * i, 32'h2000 + i, 1'b0);
      sample();
      chk($sformatf("t3_gnt_%0d", i), d_gnt, 1);
      chk($sformatf("t3_stall_%0d", i), c_stall, 1);
      next_cycle();
    end
    d_set(1'b1, 32'h820, 32'h2008, 1'b0);
    sample();
    chk("t3_cslot_stall", c_stall, 0);
    chk("t3_cslot_dgnt", d_gnt, 0);
    chk("t3_cslot_rdata", c_rdata, 32'h1000);
    next_cycle();
    c_rd = 0;
    for (int i = 8; i < 12; i++) begin
      d_set(1'b1, 32'h800 + 4 * i, 32'h2000 + i, i == 11);
      sample();
      chk($sformatf("t3_gnt_%0d", i), d_gnt, 1);
      next_cycle();
    end
    idle_inputs();
    c_rd = 1; c_addr = 32'h81C;
    sample();
    chk("t3_rd_81c", c_rdata, 32'h2007);
    next_cycle();
    c_addr = 32'h82C;
    sample();
    chk("t3_rd_82c", c_rdata, 32'h200B);
    next_cycle();

    // T4: C every cycle, D holds a read request -> forced slot every 16th cycle
    c_rd = 1; c_addr = 32'h400;
    d_set(1'b0, 32'h804, 32'h0, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      sample();
      chk($sformatf("t4_gnt_%0d", k), d_gnt, (k == 16 || k == 32) ? 1 : 0);
      chk($sformatf("t4_stall_%0d", k), c_stall, (k == 16 || k == 32) ? 1 : 0);
      chk($sformatf("t4_rvalid_%0d", k), d_rvalid, (k == 17) ? 1 : 0);
      if (k == 17) chk("t4_rdata", d_rdata, 32'h2001);
      next_cycle();
    end
    idle_inputs();
    sample();
    chk("t4_rvalid_33", d_rvalid, 1);
    next_cycle();

    // T5: C writes BCD, D reads it back through the MMIO address
    c_wr = 1; c_addr = 32'h40000010; c_wdata = 32'h1234;
    sample();
    chk("t5_wr_stall", c_stall, 0);
    next_cycle();
    c_wr = 0;
    d_set(1'b0, 32'h40000010, 32'h0, 1'b1);
    sample();
    chk("t5_gnt", d_gnt, 1);
    chk("t5_m_rd", m_rd, 1);
    chk("t5_m_wr", m_wr, 0);
    chk("t5_m_addr", m_addr, 32'h40000010);
    chk("t5_c_rdata", c_rdata, 0);
    chk("t5_rvalid_early", d_rvalid, 0);
    next_cycle();
    idle_inputs();
    sample();
    chk("t5_rvalid", d_rvalid, 1);
    chk("t5_rdata", d_rdata, 32'h1234);
    next_cycle();
    sample();
    chk("t5_rvalid_drop", d_rvalid, 0);
    chk("t5_rdata_hold", d_rdata, 32'h1234);
    next_cycle();

    // T6: reset in the middle of a DEV burst
    d_set(1'b1, 32'hC00, 32'h3000, 1'b0);
    sample();
    chk("t6_b0_gnt", d_gnt, 1);
    next_cycle();
    d_set(1'b0, 32'hC00, 32'h0, 1'b0);
    sample();
    chk("t6_b1_gnt", d_gnt, 1);
    chk("t6_b1_m_rd", m_rd, 1);
    next_cycle();
    d_set(1'b1, 32'hC08, 32'hDEAD, 1'b0);
    c_rd = 1; c_addr = 32'h400;
    #1;
    chk("t6_pre_rvalid", d_rvalid, 1);
    chk("t6_pre_rdata", d_rdata, 32'h3000);
    chk("t6_pre_gnt", d_gnt, 1);
    chk("t6_pre_stall", c_stall, 1);
    chk("t6_pre_m_wr", m_wr, 1);
    reset = 1;
    #1;
    chk("t6_rst_gnt", d_gnt, 0);
    chk("t6_rst_m_wr", m_wr, 0);
    chk("t6_rst_m_rd", m_rd, 0);
    chk("t6_rst_stall", c_stall, 0);
    chk("t6_rst_rvalid", d_rvalid, 0);
    chk("t6_rst_rdata", d_rdata, 0);
    next_cycle();
    reset = 0;
    sample();
    chk("t6_post_stall", c_stall, 0);
    chk("t6_post_dgnt", d_gnt, 0);
    chk("t6_post_rvalid", d_rvalid, 0);
    chk("t6_post_rdata", c_rdata, 32'h1000);
    next_cycle();
    idle_inputs();
    c_rd = 1; c_addr = 32'hC08;
    sample();
    chk("t6_abandoned", c_rdata, 0);
    next_cycle();
    c_addr = 32'hC00;
    sample();
    chk("t6_committed", c_rdata, 32'h3000);
    next_cycle();
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
